// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press, release and long-press pulses.
// All channels share one synchronizer bank and one slow debounce tick.
`timescale 1ns/1ps
module key_debounce_multi #(
    parameter int N_KEYS     = 4,
    parameter int CLK_DIV    = 50_000,
    parameter int DEB_TICKS  = 20,
    parameter int LONG_TICKS = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W  = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [N_KEYS-1:0] IDLE_RAW = ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync1_r;
    logic [N_KEYS-1:0] sync2_r;
    logic [N_KEYS-1:0] act_s;
    logic [DIV_W-1:0]  div_r;
    logic              tick_r;

    // Two-flop synchronizer; flops idle at the raw not-pressed level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= IDLE_RAW;
            sync2_r <= IDLE_RAW;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    assign act_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

    // Shared tick: one clk wide, raised as the divider wraps to zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (div_r == DIV_W'(CLK_DIV - 1)) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            div_r  <= div_r + DIV_W'(1'b1);
            tick_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        state_t            state_r;
        logic [DEB_W-1:0]  deb_r;
        logic [HOLD_W-1:0] hold_r;
        logic              level_r;
        logic              press_r;
        logic              release_r;
        logic              long_r;
        logic              deb_done_s;
        logic              hold_sat_s;
        logic              hold_last_s;

        assign deb_done_s  = (deb_r == DEB_W'(DEB_TICKS - 1));
        assign hold_sat_s  = (hold_r == HOLD_W'(LONG_TICKS));
        assign hold_last_s = (hold_r == HOLD_W'(LONG_TICKS - 1));

        // Channel FSM; a transition clk never also counts a tick
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_r   <= IDLE;
                deb_r     <= {DEB_W{1'b0}};
                hold_r    <= {HOLD_W{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (act_s[g]) begin
                            state_r <= PRESS_WAIT;
                            deb_r   <= {DEB_W{1'b0}};
                        end
                    end
                    PRESS_WAIT: begin
                        if (!act_s[g]) begin
                            state_r <= IDLE;
                            deb_r   <= {DEB_W{1'b0}};
                        end else if (tick_r) begin
                            if (deb_done_s) begin
                                state_r <= HELD;
                                deb_r   <= {DEB_W{1'b0}};
                                hold_r  <= {HOLD_W{1'b0}};
                                press_r <= 1'b1;
                                level_r <= 1'b1;
                            end else begin
                                deb_r <= deb_r + DEB_W'(1'b1);
                            end
                        end
                    end
                    HELD: begin
                        if (!act_s[g]) begin
                            state_r <= RELEASE_WAIT;
                            deb_r   <= {DEB_W{1'b0}};
                        end else if (tick_r && !hold_sat_s) begin
                            hold_r <= hold_r + HOLD_W'(1'b1);
                            long_r <= hold_last_s;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (act_s[g]) begin
                            state_r <= HELD;
                        end else if (tick_r) begin
                            // Hold time keeps running so release bounce cannot delay a long press
                            if (!hold_sat_s) begin
                                hold_r <= hold_r + HOLD_W'(1'b1);
                                long_r <= hold_last_s;
                            end
                            if (deb_done_s) begin
                                state_r   <= IDLE;
                                deb_r     <= {DEB_W{1'b0}};
                                release_r <= 1'b1;
                                level_r   <= 1'b0;
                            end else begin
                                deb_r <= deb_r + DEB_W'(1'b1);
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        deb_r   <= {DEB_W{1'b0}};
                        hold_r  <= {HOLD_W{1'b0}};
                        level_r <= 1'b0;
                    end
                endcase
            end
        end

        assign key_level[g]     = level_r;
        assign press_pulse[g]   = press_r;
        assign release_pulse[g] = release_r;
        assign long_pulse[g]    = long_r;
    end

endmodule
